// File: rtl/sram_arb_pkg.sv
// Shared types and helpers for the SRAM arbiter.
package sram_arb_pkg;

  // Top-level sequencer states.
  typedef enum logic [0:0] {
    ST_INIT,
    ST_RUN
  } state_e;

  // Width of a requester index; never less than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr_i, wrapping.
module rr_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned NumReq = 4,
  parameter int unsigned IdW    = 2
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdW-1:0]    ptr_i,
  output logic [NumReq-1:0] gnt_o,
  output logic [IdW-1:0]    gnt_idx_o,
  output logic              gnt_valid_o
);

  // Scan ptr, ptr+1, ... modulo NumReq and stop at the first request.
  always_comb begin
    int unsigned idx;
    idx         = 0;
    gnt_o       = '0;
    gnt_idx_o   = '0;
    gnt_valid_o = 1'b0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      idx = (32'(ptr_i) + k) % NumReq;
      if (!gnt_valid_o && req_i[idx]) begin
        gnt_valid_o = 1'b1;
        gnt_o[idx]  = 1'b1;
        gnt_idx_o   = IdW'(idx);
      end
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin arbiter and command sequencer for a single-port SRAM.
// Grants one requester per cycle, registers the command onto the SRAM pins and
// returns tagged read data two cycles after the grant.
// Build option: define SRAM_ARB_INIT_EN to zero-fill INIT_WORDS words after reset.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned INIT_WORDS = 65536,
  localparam int unsigned ID_WIDTH  = clog2_min1(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           rsp_valid,
  output logic [ID_WIDTH-1:0]            rsp_id,
  output logic [DATA_WIDTH-1:0]          rsp_data,
  output logic                           sram_we,
  output logic                           sram_re,
  output logic [ADDR_WIDTH-1:0]          sram_addr,
  output logic [DATA_WIDTH-1:0]          sram_wdata,
  input  logic [DATA_WIDTH-1:0]          sram_rdata,
  output logic                           init_done
);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("NUM_REQ must be in 2..8");
  end
  if (INIT_WORDS < 1 || 64'(INIT_WORDS) > (64'd1 << ADDR_WIDTH)) begin : g_bad_init_words
    $error("INIT_WORDS must be in 1..2**ADDR_WIDTH");
  end

`ifdef SRAM_ARB_INIT_EN
  localparam state_e ResetState = ST_INIT;
  localparam logic [ADDR_WIDTH:0] LastInit = (ADDR_WIDTH + 1)'(INIT_WORDS - 1);
  logic [ADDR_WIDTH:0] init_cnt_q, init_cnt_d;
`else
  localparam state_e ResetState = ST_RUN;
`endif

  state_e                 state_q, state_d;
  logic                   init_done_q, init_done_d;
  logic [ID_WIDTH-1:0]    ptr_q, ptr_d;
  logic                   sram_we_q, sram_we_d;
  logic                   sram_re_q, sram_re_d;
  logic [ADDR_WIDTH-1:0]  sram_addr_q, sram_addr_d;
  logic [DATA_WIDTH-1:0]  sram_wdata_q, sram_wdata_d;
  logic [ID_WIDTH-1:0]    cmd_id_q, cmd_id_d;
  logic                   rsp_valid_q;
  logic [ID_WIDTH-1:0]    rsp_id_q;

  logic [NUM_REQ-1:0]     gnt;
  logic [ID_WIDTH-1:0]    gnt_idx;
  logic                   gnt_any;
  logic                   accept;
  logic                   hs;

  rr_arbiter #(
    .NumReq (NUM_REQ),
    .IdW    (ID_WIDTH)
  ) u_rr_arbiter (
    .req_i       (req_valid),
    .ptr_i       (ptr_q),
    .gnt_o       (gnt),
    .gnt_idx_o   (gnt_idx),
    .gnt_valid_o (gnt_any)
  );

  // init_done_q is clear throughout reset, so this also keeps req_ready low then.
  assign accept    = (state_q == ST_RUN) && init_done_q;
  assign req_ready = accept ? gnt : '0;
  assign hs        = accept && gnt_any;

  // Next-state: init sweep, arbitration pointer and the command to register onto the pins.
  always_comb begin
    state_d      = state_q;
    init_done_d  = init_done_q;
    ptr_d        = ptr_q;
    sram_we_d    = 1'b0;
    sram_re_d    = 1'b0;
    sram_addr_d  = sram_addr_q;
    sram_wdata_d = sram_wdata_q;
    cmd_id_d     = cmd_id_q;
`ifdef SRAM_ARB_INIT_EN
    init_cnt_d   = init_cnt_q;
`endif
    unique case (state_q)
      ST_INIT: begin
`ifdef SRAM_ARB_INIT_EN
        sram_we_d    = 1'b1;
        sram_addr_d  = init_cnt_q[ADDR_WIDTH-1:0];
        sram_wdata_d = '0;
        init_cnt_d   = init_cnt_q + 1'b1;
        if (init_cnt_q == LastInit) begin
          state_d     = ST_RUN;
          init_done_d = 1'b1;
        end
`else
        state_d = ST_RUN;
`endif
      end
      ST_RUN: begin
        init_done_d = 1'b1;
        if (hs) begin
          sram_we_d    = req_write[gnt_idx];
          sram_re_d    = ~req_write[gnt_idx];
          sram_addr_d  = req_addr[32'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
          sram_wdata_d = req_wdata[32'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
          cmd_id_d     = gnt_idx;
          ptr_d        = (32'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + ID_WIDTH'(1);
        end
      end
      default: state_d = ResetState;
    endcase
  end

  // State, command and response registers; reset drops anything in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ResetState;
      init_done_q  <= 1'b0;
      ptr_q        <= '0;
      sram_we_q    <= 1'b0;
      sram_re_q    <= 1'b0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
      cmd_id_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
`ifdef SRAM_ARB_INIT_EN
      init_cnt_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      init_done_q  <= init_done_d;
      ptr_q        <= ptr_d;
      sram_we_q    <= sram_we_d;
      sram_re_q    <= sram_re_d;
      sram_addr_q  <= sram_addr_d;
      sram_wdata_q <= sram_wdata_d;
      cmd_id_q     <= cmd_id_d;
      // Second stage of the read-tag pipeline: data arrives the cycle after sram_re.
      rsp_valid_q  <= sram_re_q;
      rsp_id_q     <= cmd_id_q;
`ifdef SRAM_ARB_INIT_EN
      init_cnt_q   <= init_cnt_d;
`endif
    end
  end

  assign sram_we    = sram_we_q;
  assign sram_re    = sram_re_q;
  assign sram_addr  = sram_addr_q;
  assign sram_wdata = sram_wdata_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_data   = sram_rdata;
  assign init_done  = init_done_q;

endmodule
